mio_bus_responder: RTL and testbench

Memory/IO-side responder for the multi-cycle CPU's MIO bus. It accepts one request at a time from the CPU's request outputs (`CPU_MIO`, `mem_w`, `Addr_out`, `data_out`) and completes it after a fixed number of wait states. It performs the access against on-chip word RAM or a small peripheral register file, then pulses `MIO_ready` with read data on `data_in`. It sits between the CPU top and the board I/O.

---
 rtl/mio_pkg.sv | 21 ++
 rtl/mio_ram.sv | 24 ++
 rtl/mio_bus_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mio_bus_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: region codes, peripheral
// register offsets and the responder FSM state encoding.
package mio_pkg;

    // Region codes decoded from Addr_out[31:28]
    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_IO  = 4'hE;

    // Peripheral register offsets decoded from Addr_out[3:2]
    localparam logic [1:0] IO_LED = 2'd0;
    localparam logic [1:0] IO_SW  = 2'd1;
    localparam logic [1:0] IO_CNT = 2'd2;
    localparam logic [1:0] IO_ERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous word RAM with one cycle of read latency.
// Read-before-write; contents are intentionally not reset.
module mio_ram #(
    parameter int AW     = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    // Registered read of the addressed word, optional write to the same word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: accepts one CPU request at a time, inserts a fixed
// number of wait states, then acknowledges with a one-cycle MIO_ready pulse.
// Targets are the on-chip word RAM and a small peripheral register file.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_AW        = 10,
    parameter int          WAIT_CYCLES   = 1,
    parameter logic [31:0] UNMAPPED_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        MIO_ready,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        bus_err
);

    // Wait counter is preloaded with WAIT_CYCLES-1 so that reaching zero
    // marks the last wait cycle.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, next_state;

    logic [3:0]        wait_cnt;
    logic [3:0]        reg_q;
    logic [RAM_AW-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              we_q;

    logic [3:0]        req_region;
    logic [RAM_AW-1:0] req_idx;
    logic              req_we;

    logic              accept;
    logic              enter_ack;
    logic              commit;
    logic              lat_ram;
    logic              lat_io;
    logic              lat_unmapped;
    logic              ram_we;

    logic [31:0]       cnt;
    logic [31:0]       rdata_q;
    logic [31:0]       ram_rdata;
    logic [31:0]       rd_value;

    // Address bits outside the decoded fields are deliberately ignored
    logic unused_addr;
    assign unused_addr = ^{Addr_out[27:RAM_AW+2], Addr_out[1:0]};

    // Peripheral read mux
    function automatic logic [31:0] periph_read(
        input logic [1:0]  off,
        input logic [15:0] led_v,
        input logic [15:0] sw_v,
        input logic [31:0] cnt_v,
        input logic        err_v
    );
        logic [31:0] v;
        case (off)
            IO_LED:  v = {16'h0000, led_v};
            IO_SW:   v = {16'h0000, sw_v};
            IO_CNT:  v = cnt_v;
            default: v = {31'h0, err_v};
        endcase
        return v;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the acknowledge output
    always_comb begin
        next_state = state;
        MIO_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (CPU_MIO) begin
                    next_state = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                MIO_ready  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Wait-state countdown, loaded on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Latch the request on acceptance; later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            reg_q   <= Addr_out[31:28];
            idx_q   <= Addr_out[RAM_AW+1:2];
            wdata_q <= data_out;
            we_q    <= mem_w;
        end
    end

    // With zero wait states ACK is entered on the accepting edge, before the
    // latched copy exists, so the live request is used while in IDLE.
    always_comb begin
        accept     = (state == IDLE) && CPU_MIO;
        enter_ack  = (next_state == ACK) && (state != ACK);
        commit     = (state == ACK);
        req_region = (state == IDLE) ? Addr_out[31:28]      : reg_q;
        req_idx    = (state == IDLE) ? Addr_out[RAM_AW+1:2] : idx_q;
        req_we     = (state == IDLE) ? mem_w                : we_q;
        lat_ram      = (reg_q == REG_RAM);
        lat_io       = (reg_q == REG_IO);
        lat_unmapped = !lat_ram && !lat_io;
        ram_we       = commit && we_q && lat_ram;
        rd_value     = (req_region == REG_IO)
                       ? periph_read(req_idx[1:0], led, sw, cnt, bus_err)
                       : UNMAPPED_DATA;
    end

    mio_ram #(
        .AW     (RAM_AW),
        .DATA_W (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Read-data hold register: peripheral/unmapped data captured entering
    // ACK, RAM data captured leaving ACK so data_in stays put afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if (enter_ack && !req_we && req_region != REG_RAM) begin
            rdata_q <= rd_value;
        end else if (commit && !we_q && lat_ram) begin
            rdata_q <= ram_rdata;
        end
    end

    assign data_in = (commit && !we_q && lat_ram) ? ram_rdata : rdata_q;

    // LED register, written when the ACK cycle ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= 16'h0;
        end else if (commit && we_q && lat_io && idx_q[1:0] == IO_LED) begin
            led <= wdata_q[15:0];
        end
    end

    // Free-running cycle counter; a bus write overrides the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 32'h0;
        end else if (commit && we_q && lat_io && idx_q[1:0] == IO_CNT) begin
            cnt <= wdata_q;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // Sticky bus error: set by unmapped accesses, cleared by writing IO_ERR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (commit && lat_unmapped) begin
            bus_err <= 1'b1;
        end else if (commit && we_q && lat_io && idx_q[1:0] == IO_ERR) begin
            bus_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: the stimulus process predicts each
// acknowledge from a behavioural model and queues it; a monitor pops and
// compares whenever MIO_ready is seen.
module tb_mio_bus_responder;

    localparam int W = 1;

    logic        clk;
    logic        reset;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        MIO_ready;
    logic [15:0] sw;
    logic [15:0] led;
    logic        bus_err;

    mio_bus_responder #(
        .RAM_AW        (10),
        .WAIT_CYCLES   (W),
        .UNMAPPED_DATA (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .CPU_MIO   (CPU_MIO),
        .mem_w     (mem_w),
        .Addr_out  (Addr_out),
        .data_out  (data_out),
        .data_in   (data_in),
        .MIO_ready (MIO_ready),
        .sw        (sw),
        .led       (led),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [31:0] data;
        logic [15:0] led;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] ram_m [1024];
    bit          ram_known [1024];
    logic [15:0] led_m;
    logic        err_m;
    logic [31:0] cnt_val;
    int          cnt_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_ready: no pulse observed, expected at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (MIO_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk) check("read_data", data_in, e.data);
                    check("led_at_ack", {16'h0, led}, {16'h0, e.led});
                    check("err_at_ack", {31'h0, bus_err}, {31'h0, e.err});
                end
            end
        end
    end

    // Issue one access (called #1 after a rising edge); predicts the response
    // from the address map rules, then applies the write effects to the model.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [15:0] swv);
        int          s;
        int          c;
        exp_t        e;
        logic [3:0]  region;
        logic [9:0]  idx;
        logic [1:0]  off;
        s      = cyc + 1;
        c      = s + W + 1;
        region = addr[31:28];
        idx    = addr[11:2];
        off    = addr[3:2];
        CPU_MIO  = 1'b1;
        mem_w    = we;
        Addr_out = addr;
        data_out = data;
        sw       = swv;
        e.cyc  = s + W;
        e.led  = led_m;
        e.err  = err_m;
        e.chk  = 1'b0;
        e.data = 32'h0;
        if (!we) begin
            if (region == 4'h0) begin
                e.chk  = ram_known[idx];
                e.data = ram_m[idx];
            end else if (region == 4'hE) begin
                e.chk = 1'b1;
                case (off)
                    2'd0: e.data = {16'h0, led_m};
                    2'd1: e.data = {16'h0, swv};
                    2'd2: e.data = cnt_val + 32'(s + W - 1 - cnt_edge);
                    default: e.data = {31'h0, err_m};
                endcase
            end else begin
                e.chk  = 1'b1;
                e.data = 32'h0;
            end
        end
        exp_q.push_back(e);
        if (region == 4'h0) begin
            if (we) begin
                ram_m[idx]     = data;
                ram_known[idx] = 1'b1;
            end
        end else if (region == 4'hE) begin
            if (we) begin
                case (off)
                    2'd0: led_m = data[15:0];
                    2'd1: ;
                    2'd2: begin cnt_val = data; cnt_edge = c; end
                    default: err_m = 1'b0;
                endcase
            end
        end else begin
            err_m = 1'b1;
        end
        @(posedge clk);
        #1;
        // Scramble the bus after acceptance; only the latched request counts
        CPU_MIO  = 1'($urandom);
        mem_w    = 1'($urandom);
        Addr_out = $urandom;
        data_out = $urandom;
        repeat (W + 1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        CPU_MIO  = 1'b0;
        Addr_out = $urandom;
        repeat (k) @(posedge clk);
        #1;
    endtask

    logic [31:0] a;
    logic [3:0]  rg;

    initial begin
        reset    = 1'b1;
        CPU_MIO  = 1'b0;
        mem_w    = 1'b0;
        Addr_out = 32'h0;
        data_out = 32'h0;
        sw       = 16'h0;
        led_m    = 16'h0;
        err_m    = 1'b0;
        cnt_val  = 32'h0;
        cnt_edge = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'h0, MIO_ready}, 32'h0);
        check("reset_data",  data_in, 32'h0);
        check("reset_led",   {16'h0, led}, 32'h0);
        check("reset_err",   {31'h0, bus_err}, 32'h0);
        reset    = 1'b0;
        cnt_edge = cyc;

        // RAM write/read
        do_access(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 16'h0);
        do_access(1'b0, 32'h0000_0010, 32'h0, 16'h0);
        // Aliasing above the RAM index width
        do_access(1'b1, 32'h0000_1004, 32'h1234_5678, 16'h0);
        do_access(1'b0, 32'h0000_0004, 32'h0, 16'h0);
        // LED and switches
        do_access(1'b1, 32'hE000_0000, 32'hFFFF_00A5, 16'h0);
        check("led_after_write", {16'h0, led}, 32'h0000_00A5);
        do_access(1'b0, 32'hE000_0004, 32'h0, 16'h3C3C);
        // Unmapped access and error register
        do_access(1'b0, 32'h4000_0000, 32'h0, 16'h0);
        check("err_after_unmapped", {31'h0, bus_err}, 32'h1);
        do_access(1'b0, 32'hE000_000C, 32'h0, 16'h0);
        do_access(1'b1, 32'hE000_000C, 32'h0, 16'h0);
        check("err_after_clear", {31'h0, bus_err}, 32'h0);
        // Counter load followed by an immediate read
        do_access(1'b1, 32'hE000_0008, 32'h0000_0100, 16'h0);
        do_access(1'b0, 32'hE000_0008, 32'h0, 16'h0);
        idle(2);

        // Randomized mix of RAM, peripheral and unmapped traffic
        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                a = {4'h0, 16'($urandom), 5'($urandom_range(0, 31)), 5'b0, 2'($urandom)};
                a[6:2] = 5'($urandom_range(0, 31));
            end else if (kind <= 7) begin
                a = {4'hE, 26'($urandom), 2'($urandom)};
            end else begin
                rg = ($urandom % 2 == 0) ? 4'hF : 4'($urandom_range(1, 13));
                a  = {rg, 28'($urandom)};
            end
            do_access(1'($urandom), a, $urandom, 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Reset during the wait state of a RAM write
        do_access(1'b1, 32'h0000_0020, 32'hA5A5_0001, 16'h0);
        do_access(1'b1, 32'hE000_0000, 32'h0000_1234, 16'h0);
        do_access(1'b0, 32'h7000_0000, 32'h0, 16'h0);
        do_access(1'b0, 32'h0000_0020, 32'h0, 16'h0);
        CPU_MIO  = 1'b1;
        mem_w    = 1'b1;
        Addr_out = 32'h0000_0020;
        data_out = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        CPU_MIO = 1'b0;
        #1;
        check("midreset_ready", {31'h0, MIO_ready}, 32'h0);
        check("midreset_data",  data_in, 32'h0);
        check("midreset_led",   {16'h0, led}, 32'h0);
        check("midreset_err",   {31'h0, bus_err}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        led_m    = 16'h0;
        err_m    = 1'b0;
        cnt_val  = 32'h0;
        cnt_edge = cyc;
        idle(3);
        do_access(1'b0, 32'h0000_0020, 32'h0, 16'h0);
        do_access(1'b0, 32'hE000_0008, 32'h0, 16'h0);
        idle(6);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
